// File: rtl/irrigation_pkg.sv
// Shared types for the irrigation request sequencer and the actuator-side block:
// sequencer state encodings and tank level codes with their thresholds.
package irrigation_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StIrrigate = 3'b001,
    StHold     = 3'b010,
    StCooldown = 3'b011,
    StAlarm    = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    TankEmpty  = 2'b00,
    TankLow    = 2'b01,
    TankMedium = 2'b10,
    TankFull   = 2'b11
  } tank_level_e;

  function automatic logic tank_low(logic [1:0] level);
    return level <= TankLow;
  endfunction

  function automatic logic tank_ok(logic [1:0] level);
    return level >= TankMedium;
  endfunction

endpackage

// File: rtl/irrigation_request_fsm_if.sv
// Sensor/operator inputs and request/alarm outputs of the irrigation request sequencer.
// The slave modport is the sequencer itself; master is whatever drives the sensors.
interface irrigation_request_fsm_if;
  logic       soilDry;
  logic [1:0] tankLevel;
  logic       switch;
  logic       yIn;
  logic       cOut;
  logic       alarm;
  logic [2:0] mef1State;

  modport master (
    output soilDry, tankLevel, switch, yIn,
    input  cOut, alarm, mef1State
  );

  modport slave (
    input  soilDry, tankLevel, switch, yIn,
    output cOut, alarm, mef1State
  );
endinterface

// File: rtl/irrigation_request_fsm_cycle_timer.sv
// cycle_timer: saturating up-counter with synchronous clear/load and an equality flag.
// Priority is clear, then load, then increment.
module cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] cmp_val_i,
  output logic [Width-1:0] count_o,
  output logic             eq_o
);
  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign eq_o    = (count_q == cmp_val_i);
endmodule

// File: rtl/irrigation_request_fsm.sv
// Irrigation request sequencer: min on-time, cooldown, low-water alarm with hysteresis.
// Define IRRIGATION_WATCHDOG_EN to add a watchdog on continuous irrigation time.
module irrigation_request_fsm
  import irrigation_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES   = 8,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned TIMER_W         = 8,
  parameter int unsigned WATCHDOG_CYCLES = 200
) (
  input logic                     clock,
  input logic                     reset,
  irrigation_request_fsm_if.slave bus
);
  localparam logic [TIMER_W-1:0] MinOnLast = TIMER_W'(MIN_ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CoolLast  = TIMER_W'(COOLDOWN_CYCLES - 1);

  if (MIN_ON_CYCLES == 0 || MIN_ON_CYCLES >= (1 << TIMER_W) ||
      COOLDOWN_CYCLES == 0 || COOLDOWN_CYCLES >= (1 << TIMER_W) ||
      WATCHDOG_CYCLES == 0 || WATCHDOG_CYCLES >= (1 << TIMER_W)) begin : g_param_check
    $error("irrigation_request_fsm: cycle parameter outside 1 .. 2^TIMER_W-1");
  end

  state_e             state_d, state_q;
  logic               cout_q, alarm_q;
  logic               tmr_clr, tmr_inc, cool_done, wd_expire;
  logic [TIMER_W-1:0] tmr_count;
  logic               low, ok;

  assign low = tank_low(bus.tankLevel);
  assign ok  = tank_ok(bus.tankLevel);

  cycle_timer #(
    .Width (TIMER_W)
  ) u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (tmr_inc),
    .cmp_val_i  (CoolLast),
    .count_o    (tmr_count),
    .eq_o       (cool_done)
  );

`ifdef IRRIGATION_WATCHDOG_EN
  localparam logic [TIMER_W-1:0] WdLast = TIMER_W'(WATCHDOG_CYCLES - 1);
  logic               wd_clr;
  logic [TIMER_W-1:0] wd_count;

  // Holds its value across HOLD so a paused irrigation still counts toward the limit.
  assign wd_clr = (state_q == StIdle) || (state_q == StCooldown) || (state_q == StAlarm);

  cycle_timer #(
    .Width (TIMER_W)
  ) u_watchdog (
    .clk_i      (clock),
    .rst_i      (reset),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (state_q == StIrrigate),
    .cmp_val_i  (WdLast),
    .count_o    (wd_count),
    .eq_o       (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    case (state_q)
      StIdle: begin
        tmr_clr = 1'b1;
        if (low) begin
          state_d = StAlarm;
        end else if (bus.soilDry && !bus.switch) begin
          state_d = StIrrigate;
        end
      end
      StIrrigate: begin
        if (low || wd_expire) begin
          state_d = StAlarm;
          tmr_clr = 1'b1;
        end else if (bus.switch) begin
          // The cycle that sees the pause was still an on-cycle, so it counts.
          state_d = StHold;
          tmr_inc = 1'b1;
        end else if ((tmr_count >= MinOnLast) && !bus.soilDry) begin
          state_d = StCooldown;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      StHold: begin
        if (low) begin
          state_d = StAlarm;
          tmr_clr = 1'b1;
        end else if (bus.switch || bus.yIn) begin
          state_d = StHold;
        end else if (bus.soilDry) begin
          state_d = StIrrigate;
        end else begin
          state_d = StCooldown;
          tmr_clr = 1'b1;
        end
      end
      StCooldown: begin
        if (low) begin
          state_d = StAlarm;
          tmr_clr = 1'b1;
        end else if (cool_done) begin
          state_d = StIdle;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      StAlarm: begin
        tmr_clr = 1'b1;
        if (ok && !bus.switch) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cout_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cout_q  <= (state_d == StIrrigate);
      alarm_q <= (state_d == StAlarm);
    end
  end

  assign bus.cOut      = cout_q;
  assign bus.alarm     = alarm_q;
  assign bus.mef1State = state_q;
endmodule

// File: doc/irrigation_request_fsm.md
# irrigation_request_fsm

Upstream sequencer of the automatic irrigation system. It samples soil-dryness, tank level and the operator switch, and decides when irrigation is requested. It drives the request line `cOut` into the irrigation-actuator FSM's `cIn`, and consumes that FSM's `yOut` hand-back as `yIn`. It enforces a minimum irrigation on-time and a post-irrigation cooldown, and raises a low-water alarm that blocks all requests.

## Interface
- `MIN_ON_CYCLES`, default 8: minimum cycles `cOut` stays high once irrigation starts (1 .. 2^TIMER_W−1).
- `COOLDOWN_CYCLES`, default 16: cycles spent in COOLDOWN before a new request is allowed (1 .. 2^TIMER_W−1).
- `TIMER_W`, default 8: width of the shared cycle timer.
- `WATCHDOG_CYCLES`, default 200: maximum continuous IRRIGATE cycles; used only with the watchdog enabled.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `soilDry` input 1: 1 = soil below moisture threshold.
- `tankLevel` input 2: 00 empty, 01 low, 10 medium, 11 full.
- `switch` input 1: operator pause, shared with the actuator FSM.
- `yIn` input 1: actuator hand-back; high = actuator idle and held by switch.
- `cOut` output 1: irrigation request to actuator `cIn`.
- `alarm` output 1: low-water alarm.
- `mef1State` output 3: current state encoding, for debug/LEDs.

## Operation
- States and encodings: IDLE=000, IRRIGATE=001, HOLD=010, COOLDOWN=011, ALARM=100. Other codes go to IDLE on the next cycle.
- `tankLow` = (`tankLevel` ≤ 01). `tankOk` = (`tankLevel` ≥ 10).
- Priority in every non-ALARM state: `tankLow` → ALARM, checked before any other transition.
- IDLE: `cOut`=0. If `soilDry` & !`switch`, go to IRRIGATE and clear the timer.
- IRRIGATE: `cOut`=1. Timer increments, saturating at its maximum.
  - If `switch`, go to HOLD; the timer is preserved.
  - Otherwise, if timer ≥ MIN_ON_CYCLES−1 and !`soilDry`, go to COOLDOWN and clear the timer.
  - `soilDry` falling before the minimum does not end irrigation.
- HOLD: `cOut`=0. Stay while `switch` | `yIn`.
  - On release, go to IRRIGATE with the timer resumed if `soilDry`.
  - Otherwise go to COOLDOWN and clear the timer.
- COOLDOWN: `cOut`=0. Timer increments. When timer = COOLDOWN_CYCLES−1, go to IDLE. `soilDry` is ignored in this state.
- ALARM: `cOut`=0, `alarm`=1. Exit to IDLE only when `tankOk` & !`switch` in the same cycle; this is level hysteresis. The timer is cleared.
- Simultaneous `tankLow` and `switch` in IRRIGATE: go to ALARM.
- `cOut`, `alarm` and `mef1State` are registered, derived from next-state (Moore, registered outputs).

## Timing
- Reset: state=IDLE, timer=0, `cOut`=0, `alarm`=0, `mef1State`=000. Reset wins over every input. Asserting reset mid-IRRIGATE drops `cOut` on the next edge.
- Input-to-output latency: 1 cycle. Inputs are sampled at edge N; `cOut`/`alarm` reflect the new state after edge N.
- Irrigation with `soilDry` cleared immediately after start:
  - `cOut` is high for exactly MIN_ON_CYCLES cycles.
  - Then COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.
  - IDLE is then held for at least 1 cycle before re-request.
- Inputs are already synchronous to `clock`; no synchronizers are inside this block.

## Configuration
- `IRRIGATION_WATCHDOG_EN` defined:
  - A separate counter counts consecutive IRRIGATE cycles, including across HOLD resume; it is cleared in COOLDOWN, IDLE and ALARM.
  - Reaching WATCHDOG_CYCLES forces ALARM with `alarm`=1, even with `tankOk`.
  - Exit is the same as normal ALARM.
- Undefined: no watchdog counter is built. IRRIGATE lasts indefinitely while `soilDry` stays high.

## Structure
- Shared package `irrigation_pkg`: state enum/encodings, `tankLevel` codes (EMPTY/LOW/MEDIUM/FULL), `tankLow`/`tankOk` thresholds. The actuator-side block reuses the tank codes.
- One sub-module, `cycle_timer`: loadable/clearable saturating up-counter of width TIMER_W with a compare-equal output. It is instantiated once for the main timer, and a second time under `IRRIGATION_WATCHDOG_EN`.

## Test plan
All scenarios use MIN_ON_CYCLES=4, COOLDOWN_CYCLES=3 and `tankLevel`=11 unless noted.
- Reset then `soilDry`=1 for one cycle → `cOut` high for exactly 4 cycles, `mef1State` 011 for exactly 3 cycles, then 000.
- `soilDry` held 1 for 10 cycles → `cOut` stays high 10 cycles, then exits on the first edge with `soilDry`=0 → COOLDOWN.
- In IRRIGATE after 2 cycles, `switch`=1 for 5 cycles then 0 with `soilDry`=1 → `cOut`=0 during hold, resumes, and ends after 2 more cycles once `soilDry`=0.
- `tankLevel` 11→01 during IRRIGATE → next edge `cOut`=0, `alarm`=1. Return to 01 keeps ALARM. `tankLevel`=10 with `switch`=0 → IDLE.
- `reset` asserted in cycle 2 of IRRIGATE → next edge all outputs 0, state 000. Later `soilDry` restarts a full 4-cycle irrigation.
- With `IRRIGATION_WATCHDOG_EN` and WATCHDOG_CYCLES=6, `soilDry` stuck at 1 → `alarm`=1 after cycle 6 with `tankLevel`=11.
